// File: rtl/ram_dma.sv
// Block-copy engine: reads a run of RAM words and writes them back at another base, one word per cycle.
// Define DMA_OVERLAP_EN to copy descending when dst lies inside (src, src+length), so overlapping moves stay exact.
module ram_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  desc_q, desc_d;
  logic [ADDR_WIDTH-1:0] ram_write_addr_q, ram_write_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;

  logic [ADDR_WIDTH:0]   len_sat;
  logic [ADDR_WIDTH-1:0] len_m1;
  logic [ADDR_WIDTH-1:0] step;
  logic                  ovl;

  always_comb begin
    len_sat = (length > MAX_LEN) ? MAX_LEN : length;
    len_m1  = ADDR_WIDTH'(len_sat - ONE);
    step    = desc_q ? {ADDR_WIDTH{1'b1}} : {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  end

`ifdef DMA_OVERLAP_EN
  // Unsigned, non-wrapping distance; only a forward overlap needs the descending walk.
  logic [ADDR_WIDTH:0] gap;
  always_comb begin
    gap = {1'b0, dst_addr} - {1'b0, src_addr};
    ovl = (dst_addr > src_addr) && (gap < len_sat);
  end
`else
  assign ovl = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      desc_q           <= 1'b0;
      ram_write_addr_q <= '0;
      ram_data_q       <= '0;
      ram_we_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      desc_q           <= desc_d;
      ram_write_addr_q <= ram_write_addr_d;
      ram_data_q       <= ram_data_d;
      ram_we_q         <= ram_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len_sat == '0) ? DONE : RUN;
      RUN:     if (count_q == ONE) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: the read pointer doubles as the registered read address.
  always_comb begin
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    desc_d           = desc_q;
    ram_write_addr_d = ram_write_addr_q;
    ram_data_d       = ram_data_q;
    ram_we_d         = 1'b0;
    case (state_q)
      IDLE: if (start && len_sat != '0) begin
        rd_ptr_d = ovl ? src_addr + len_m1 : src_addr;
        wr_ptr_d = ovl ? dst_addr + len_m1 : dst_addr;
        count_d  = len_sat;
        desc_d   = ovl;
      end
      RUN: begin
        ram_data_d       = ram_out;
        ram_write_addr_d = wr_ptr_q;
        ram_we_d         = 1'b1;
        rd_ptr_d         = rd_ptr_q + step;
        wr_ptr_d         = wr_ptr_q + step;
        count_d          = count_q - ONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy           = (state_q == RUN) || (state_q == DRAIN);
    done           = (state_q == DONE);
    ram_read_addr  = rd_ptr_q;
    ram_write_addr = ram_write_addr_q;
    ram_data       = ram_data_q;
    ram_we         = ram_we_q;
  end
endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: behavioural RAM, per-cycle timing checks, and a write scoreboard
// filled from a reference copy of RAM when each copy is launched.
module tb_ram_dma;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_read_addr, ram_write_addr;
  logic [DW-1:0] ram_out, ram_data;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_got, mon_exp;

  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;

  always #5 clock = ~clock;

  ram_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .ram_read_addr(ram_read_addr), .ram_out(ram_out),
    .ram_write_addr(ram_write_addr), .ram_data(ram_data), .ram_we(ram_we)
  );

  assign ram_out = mem[ram_read_addr];

  always @(posedge clock) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Every DUT write must match the next expected write of the active copy.
  always @(negedge clock) begin
    if (ram_we && sb_on) begin
      mon_got = '{ram_write_addr, ram_data};
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra got addr=%0d data=%h exp none", mon_got.addr, mon_got.data);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        total++;
        assert (mon_got === mon_exp) else begin
          bad++;
          $error("FAIL sb_write got addr=%0d data=%h exp addr=%0d data=%h",
                 mon_got.addr, mon_got.data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] v);
    @(negedge clock);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = v;
    ref_mem[a] = v;
  endtask

  task automatic load_done();
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic ram_cmp(input string tag);
    int diffs, first;
    diffs = 0;
    first = -1;
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== ref_mem[a]) begin
        diffs++;
        if (first < 0) first = a;
      end
    total++;
    assert (diffs === 0) else begin
      bad++;
      $error("FAIL %s ram differs at %0d words, first addr=%0d", tag, diffs, first);
    end
  endtask

  // Called at a negedge; start is raised in that same cycle (cycle 0).
  task automatic do_copy(input string tag, input int s, input int d, input int l,
                         input int rst_cyc, input bit chk_data);
    int n, nw, lim, sa, da;
    bit desc, live;
    logic [DW-1:0] rd [DEPTH];
    n    = (l > DEPTH) ? DEPTH : l;
    desc = 1'b0;
`ifdef DMA_OVERLAP_EN
    desc = (d > s) && (d - s < n);
`endif
    nw = (rst_cyc > 0 && rst_cyc - 1 < n) ? rst_cyc - 1 : n;
    for (int i = 0; i < n; i++) begin
      sa    = desc ? (s + n - 1 - i) % DEPTH : (s + i) % DEPTH;
      rd[i] = ref_mem[sa];
    end
    for (int i = 0; i < nw; i++) begin
      da = desc ? (d + n - 1 - i) % DEPTH : (d + i) % DEPTH;
      ref_mem[da] = rd[i];
      if (chk_data) exp_q.push_back('{AW'(da), rd[i]});
    end
    sb_on    = chk_data;
    start    = 1'b1;
    src_addr = AW'(s);
    dst_addr = AW'(d);
    length   = (AW+1)'(l);
    @(posedge clock);
    #1 start = 1'b0;
    lim = (rst_cyc > 0) ? rst_cyc + 8 : n + 3;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clock);
      live = (rst_cyc == 0) || (c <= rst_cyc);
      chk($sformatf("%s busy c%0d", tag, c), busy, n > 0 && c <= n + 1 && live);
      chk($sformatf("%s we c%0d", tag, c), ram_we, c >= 2 && c <= n + 1 && live);
      chk($sformatf("%s done c%0d", tag, c), done, rst_cyc == 0 && (n == 0 ? c == 1 : c == n + 2));
      if (c == rst_cyc) reset = 1'b1;
      else if (c == rst_cyc + 1) reset = 1'b0;
    end
    chk($sformatf("%s sb_left", tag), exp_q.size(), 0);
    exp_q.delete();
    if (chk_data) ram_cmp(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst we", ram_we, 0);
    chk("rst raddr", ram_read_addr, 0);
    chk("rst waddr", ram_write_addr, 0);
    chk("rst wdata", ram_data, 0);
    reset = 1'b0;

    for (int a = 0; a < DEPTH; a++)
      load(a, (a < 4) ? DW'(32'hA0 + a) : DW'(32'h5000_0000 + a * 32'h0001_0101));
    load_done();

    do_copy("basic", 0, 16, 4, 0, 1'b1);
    do_copy("len0", 5, 9, 0, 0, 1'b1);
    do_copy("rdwrap", 62, 30, 4, 0, 1'b1);
    do_copy("wrwrap", 0, 62, 4, 0, 1'b1);
    do_copy("sat", 10, 10, 100, 0, 1'b1);
    do_copy("reset", 0, 40, 8, 3, 1'b1);

    for (int a = 0; a < 8; a++) load(a, DW'(a + 1));
    load_done();
`ifdef DMA_OVERLAP_EN
    do_copy("overlap", 0, 4, 8, 0, 1'b1);
`else
    do_copy("overlap", 0, 4, 8, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
